// File: rtl/mmio_uart_tx.sv
`default_nettype none
// mmio_uart_tx: memory-mapped UART transmitter (DATA/STATUS registers, TX FIFO, 8N1 baud-timed shifter).
// Optional macro UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_wstrb,
  input  logic        io_rstrb,
  output logic [31:0] io_rdata,
  output logic        tx_busy,
  output logic        TXD
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int PW           = AW + 1;
  localparam int CW           = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            overflow;
`ifdef UART_TX_PARITY_EN
  logic            par;
`endif

  logic            full;
  logic            empty;
  logic            cnt_last;
  logic            data_wr;
  logic            push;
  logic            drop;
  logic            status_rd;
  logic [PW-1:0]   count;
  logic [31:0]     count_wide;
  logic [2:0]      count_sat;
  logic            unused_wdata;

  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign cnt_last   = (cnt == CW'(CLKS_PER_BIT - 1));
  assign data_wr    = io_wstrb && !io_addr;
  // Overflow is judged on the pre-edge full flag, so a same-edge pop cannot rescue the store.
  assign push       = data_wr && !full;
  assign drop       = data_wr && full;
  assign status_rd  = io_rstrb && io_addr;
  assign count      = wr_ptr - rd_ptr;
  assign count_wide = 32'(count);
  assign count_sat  = (count_wide > 32'd7) ? 3'd7 : count_wide[2:0];
  assign unused_wdata = ^io_wdata[31:8];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= io_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      TXD      <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      io_rdata <= '0;
      tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);

      // A set on the same edge as a STATUS read wins over the clear.
      if (drop)           overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;

      if (io_rstrb)
        io_rdata <= io_addr ? {26'b0, count_sat, overflow, tx_busy, full} : 32'b0;

      tx_busy <= !empty || (state != IDLE);

      case (state)
        IDLE: begin
          TXD <= 1'b1;
          cnt <= '0;
          if (!empty) begin
            shreg  <= mem[rd_ptr[AW-1:0]];
`ifdef UART_TX_PARITY_EN
            par    <= ^mem[rd_ptr[AW-1:0]];
`endif
            rd_ptr <= rd_ptr + PW'(1);
            TXD    <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (cnt_last) begin
            cnt     <= '0;
            TXD     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              TXD   <= par;
              state <= PARITY;
`else
              TXD   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              TXD     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt_last) begin
            cnt   <= '0;
            TXD   <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt_last) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          TXD   <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx at CLKS_PER_BIT=10, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        io_addr = 1'b0;
  logic [31:0] io_wdata = '0;
  logic        io_wstrb = 1'b0;
  logic        io_rstrb = 1'b0;
  logic [31:0] io_rdata;
  logic        tx_busy;
  logic        TXD;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q[$];
  bit         par_q[$];
  int         frame_err = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(.CLK_FREQ_HZ(10), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_wstrb(io_wstrb), .io_rstrb(io_rstrb), .io_rdata(io_rdata),
    .tx_busy(tx_busy), .TXD(TXD)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic store(input logic [7:0] b);
    io_addr = 1'b0; io_wdata = {24'h0, b}; io_wstrb = 1'b1;
    @(negedge clk);
    io_wstrb = 1'b0;
  endtask

  task automatic load(input logic a, output logic [31:0] d);
    io_addr = a; io_rstrb = 1'b1;
    @(negedge clk);
    io_rstrb = 1'b0;
    d = io_rdata;
  endtask

  task automatic store_burst(input logic [7:0] first, input int n);
    io_addr = 1'b0; io_wstrb = 1'b1;
    for (int i = 0; i < n; i++) begin
      io_wdata = {24'h0, first + 8'(i)};
      @(negedge clk);
    end
    io_wstrb = 1'b0;
  endtask

  // Line decoder: samples mid-bit, discards frames disturbed by reset.
  initial begin : line_mon
    logic       prev;
    logic [7:0] b;
    bit         p;
    bit         aborted;
    bit         bad;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (resetn && prev && !TXD) begin
        b = '0; p = 1'b0; aborted = 1'b0; bad = 1'b0;
        repeat (5) begin @(negedge clk); if (!resetn) aborted = 1'b1; end
        if (TXD !== 1'b0) bad = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (10) begin @(negedge clk); if (!resetn) aborted = 1'b1; end
          b[i] = TXD;
        end
`ifdef UART_TX_PARITY_EN
        repeat (10) begin @(negedge clk); if (!resetn) aborted = 1'b1; end
        p = TXD;
`endif
        repeat (10) begin @(negedge clk); if (!resetn) aborted = 1'b1; end
        if (TXD !== 1'b1) bad = 1'b1;
        if (!aborted) begin
          if (bad) frame_err++;
          else begin rx_q.push_back(b); par_q.push_back(p); end
        end
      end
      prev = TXD;
    end
  end

  initial begin : main
    logic [31:0] d;
    logic [7:0]  v;
    logic        exp;
    int          n;
    int          lows;

    // Reset state
    cyc(3);
    check_eq("rst_txd", 32'(TXD), 32'd1);
    check_eq("rst_rdata", io_rdata, 32'h0);
    check_eq("rst_busy", 32'(tx_busy), 32'd0);
    resetn = 1'b1;
    cyc(1);
    load(1'b1, d);
    check_eq("rst_status", d, 32'h0);

    // Case 1: single byte 0x55, exact bit timing
    v = 8'h55;
    store(v);
    n = 1;
    check_eq("t1_txd_before", 32'(TXD), 32'd1);
    for (int k = 0; k < 10; k++) begin
      exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : v[k-1];
      cyc(2 + 10 * k - n); n = 2 + 10 * k;
      check_eq($sformatf("t1_bit%0d_first", k), 32'(TXD), 32'(exp));
      cyc(9); n += 9;
      check_eq($sformatf("t1_bit%0d_last", k), 32'(TXD), 32'(exp));
    end
    check_eq("t1_busy_in_frame", 32'(tx_busy), 32'd1);
    cyc(3);
    check_eq("t1_busy_after", 32'(tx_busy), 32'd0);
    check_eq("t1_txd_idle", 32'(TXD), 32'd1);
    check_eq("t1_rx_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check_eq("t1_rx_byte", 32'(rx_q[0]), 32'h55);
    rx_q.delete(); par_q.delete();

    // Cases 2/3: six back-to-back stores, sixth overflows; STATUS read clears overflow
    store_burst(8'h01, 6);
    load(1'b1, d);
    check_eq("t2_status", d, 32'h27);
    check_eq("t3_ovf_first", 32'(d[2]), 32'd1);
    load(1'b1, d);
    check_eq("t3_status_second", d, 32'h23);
    check_eq("t3_ovf_second", 32'(d[2]), 32'd0);
    load(1'b0, d);
    check_eq("data_load_zero", d, 32'h0);
    for (int i = 0; i < 800 && rx_q.size() < 5; i++) @(negedge clk);
    cyc(150);
    check_eq("t2_rx_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      check_eq($sformatf("t2_rx_byte%0d", i), 32'(rx_q[i]), 32'(i + 1));
    load(1'b1, d);
    check_eq("t2_status_drained", d, 32'h0);
    rx_q.delete(); par_q.delete();

    // Case 4: reset mid-frame
    store(8'hA3);
    cyc(33);
    check_eq("t4_txd_bit2", 32'(TXD), 32'd0);
    check_eq("t4_busy_pre", 32'(tx_busy), 32'd1);
    resetn = 1'b0;
    cyc(1);
    check_eq("t4_txd_reset", 32'(TXD), 32'd1);
    check_eq("t4_busy_reset", 32'(tx_busy), 32'd0);
    resetn = 1'b1;
    load(1'b1, d);
    check_eq("t4_status", d, 32'h0);
    lows = 0;
    repeat (150) begin @(negedge clk); if (TXD !== 1'b1) lows++; end
    check_eq("t4_line_quiet", 32'(lows), 32'd0);
    check_eq("t4_rx_count", 32'(rx_q.size()), 32'd0);
    rx_q.delete(); par_q.delete();

    // Case 5: store to full FIFO on the same edge the shifter pops
    store_burst(8'h11, 5);
    cyc(97);
    store(8'h99);
    load(1'b1, d);
    check_eq("t5_status", d, 32'h1E);
    check_eq("t5_count", 32'(d[5:3]), 32'd3);
    check_eq("t5_ovf", 32'(d[2]), 32'd1);
    for (int i = 0; i < 800 && rx_q.size() < 5; i++) @(negedge clk);
    cyc(150);
    check_eq("t5_rx_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      check_eq($sformatf("t5_rx_byte%0d", i), 32'(rx_q[i]), 32'(8'h11 + i));
    rx_q.delete(); par_q.delete();

`ifdef UART_TX_PARITY_EN
    // Case 6: even parity
    store(8'h07);
    for (int i = 0; i < 300 && rx_q.size() < 1; i++) @(negedge clk);
    check_eq("t6_rx_07", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF, 32'h07);
    check_eq("t6_par_07", (par_q.size() > 0) ? 32'(par_q[0]) : 32'hFFFF, 32'd1);
    cyc(30);
    store(8'h03);
    n = 1;
    cyc(92 - n); n = 92;
    check_eq("t6_par03_first", 32'(TXD), 32'd0);
    cyc(9); n += 9;
    check_eq("t6_par03_last", 32'(TXD), 32'd0);
    cyc(1); n += 1;
    check_eq("t6_stop03_first", 32'(TXD), 32'd1);
    cyc(9); n += 9;
    check_eq("t6_busy_110", 32'(tx_busy), 32'd1);
    cyc(4);
    check_eq("t6_busy_after", 32'(tx_busy), 32'd0);
    rx_q.delete(); par_q.delete();
`endif

    check_eq("frame_errors", 32'(frame_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
